// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined RISC-V core: datapath width, the
// data-memory responder state type and the word-alignment mask. The pipeline
// register modules and the hazard unit import this package as well.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) == '0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM stage and the data-memory
// responder.
//   memread_i / memwrite_i : load / store request
//   addr_i                 : byte address (ALU result)
//   wdata_i                : store data
//   rdata_o                : load data toward MEM/WB
//   stall_o                : hold upstream pipeline registers
//   done_o                 : access completes this cycle
//   err_o                  : illegal request was rejected last cycle
// master = pipeline side, slave = responder side.
interface dmem_responder_if;
    import riscv_pipe_pkg::*;

    logic            memread_i;
    logic            memwrite_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] rdata_o;
    logic            stall_o;
    logic            done_o;
    logic            err_o;

    modport master (
        output memread_i, memwrite_i, addr_i, wdata_i,
        input  rdata_o, stall_o, done_o, err_o
    );

    modport slave (
        input  memread_i, memwrite_i, addr_i, wdata_i,
        output rdata_o, stall_o, done_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word memory.
//   clk, rst : clock; asynchronous active-high reset (read register only)
//   we, re   : write / read enable, at most one set at a time
//   idx      : word index
//   wdata    : write data
//   rdata    : registered read data; holds its value when re is low
// The storage itself is never cleared.
module dmem_array
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   idx,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder behind the EX/MEM register.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : dmem_responder_if.slave (request in, rdata/stall/done/err out)
// A legal request (exactly one of read/write, word-aligned) is latched in
// IDLE, spends LATENCY cycles in BUSY while stalling the pipeline, and
// completes in DONE. Illegal requests are dropped and flagged on err_o one
// cycle later without stalling.
module dmem_responder
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q;

    logic [AW-1:0]     lat_idx_q;
    logic [XLEN-1:0]   lat_wdata_q;
    logic              lat_write_q;

    logic              legal_req;
    logic              illegal_req;
    logic              stall;
    logic              done;
    logic              acc_we;
    logic              acc_re;
    logic [XLEN-1:0]   arr_rdata;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^bus.addr_i[XLEN-1:AW+2];

    assign legal_req   = (bus.memread_i ^ bus.memwrite_i) && is_aligned(bus.addr_i);
    assign illegal_req = (bus.memread_i && bus.memwrite_i) ||
                         ((bus.memread_i || bus.memwrite_i) && !is_aligned(bus.addr_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_q == IDLE) && illegal_req;
        end
    end

    // Request latch: data only, qualified by acceptance in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && legal_req) begin
            lat_idx_q   <= bus.addr_i[AW+1:2];
            lat_wdata_q <= bus.wdata_i;
            lat_write_q <= bus.memwrite_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        acc_we  = 1'b0;
        acc_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_req) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    acc_we  = lat_write_q;
                    acc_re  = !lat_write_q;
                end
            end
            DONE: begin
                // EX/MEM advances at this edge, so its still-visible request
                // must not be accepted again.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (acc_we),
        .re    (acc_re),
        .idx   (lat_idx_q),
        .wdata (lat_wdata_q),
        .rdata (arr_rdata)
    );

    assign bus.rdata_o = arr_rdata;
    assign bus.stall_o = stall;
    assign bus.done_o  = done;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance exercised by
// a vector table, a reset-in-BUSY sequence and randomized traffic against a
// word-level memory model, plus a LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

    localparam int L2 = 2;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if2 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L2)) dut2 (
        .clk (clk), .rst (rst), .bus (if2.slave)
    );
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L1)) dut1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference state: word-indexed memory contents and last loaded value.
    logic [31:0] model_mem [int];
    logic [31:0] model_last = 32'h0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_legal;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear2();
        if2.memread_i  = 1'b0;
        if2.memwrite_i = 1'b0;
        if2.addr_i     = 32'h0;
        if2.wdata_i    = 32'h0;
    endtask

    task automatic clear1();
        if1.memread_i  = 1'b0;
        if1.memwrite_i = 1'b0;
        if1.addr_i     = 32'h0;
        if1.wdata_i    = 32'h0;
    endtask

    // Present one request on the LATENCY=2 instance, hold it until the
    // responder finishes with it, and observe an 8-cycle window.
    task automatic run_req(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           output int stall_n, output int done_at,
                           output int err_n, output int err_at,
                           output logic [31:0] rd_done, output logic [31:0] rd_end);
        logic held;
        @(posedge clk); #1;
        if2.memread_i  = rd;
        if2.memwrite_i = wr;
        if2.addr_i     = a;
        if2.wdata_i    = d;
        held    = 1'b1;
        stall_n = 0;
        done_at = -1;
        err_n   = 0;
        err_at  = -1;
        rd_done = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if2.stall_o) stall_n++;
            if (if2.err_o) begin
                err_n++;
                if (err_at < 0) err_at = c;
            end
            if (if2.done_o && done_at < 0) begin
                done_at = c;
                rd_done = if2.rdata_o;
            end
            if (held && ((c == 0 && !if2.stall_o) || if2.done_o)) begin
                @(posedge clk); #1;
                clear2();
                held = 1'b0;
            end
        end
        if (held) clear2();
        rd_end = if2.rdata_o;
    endtask

    // Apply one request and compare against the model's expectation.
    task automatic apply_and_check(input string tag, input logic rd, input logic wr,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic legal, input logic [31:0] exp_rdata);
        int stall_n, done_at, err_n, err_at;
        logic [31:0] rd_done, rd_end;
        run_req(rd, wr, a, d, stall_n, done_at, err_n, err_at, rd_done, rd_end);
        chk({tag, " stall_cycles"}, 32'(stall_n), legal ? 32'(L2 + 1) : 32'd0);
        chk({tag, " done_cycle"},   32'(done_at), legal ? 32'(L2 + 1) : 32'hFFFF_FFFF);
        chk({tag, " err_pulses"},   32'(err_n),   legal ? 32'd0 : 32'd1);
        if (!legal) chk({tag, " err_cycle"}, 32'(err_at), 32'd1);
        if (legal && rd) chk({tag, " rdata_done"}, rd_done, exp_rdata);
        chk({tag, " rdata_held"}, rd_end, exp_rdata);
    endtask

    function automatic logic spec_legal(input logic rd, input logic wr, input logic [31:0] a);
        return (rd != wr) && (a % 4 == 0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    initial begin
        clear2();
        clear1();

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_0BAD, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h1234_5678};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 1'b1, 32'h1234_5678};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset stall L2", {31'h0, if2.stall_o}, 32'h0);
        chk("reset done L2",  {31'h0, if2.done_o},  32'h0);
        chk("reset err L2",   {31'h0, if2.err_o},   32'h0);
        chk("reset rdata L2", if2.rdata_o,          32'h0);
        chk("reset stall L1", {31'h0, if1.stall_o}, 32'h0);
        chk("reset rdata L1", if1.rdata_o,          32'h0);

        for (int i = 0; i < 9; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr,
                            vecs[i].addr, vecs[i].wdata, vecs[i].exp_legal, vecs[i].exp_rdata);
        end

        // Reset in the first BUSY cycle of a store aborts it.
        @(posedge clk); #1;
        if2.memwrite_i = 1'b1;
        if2.addr_i     = 32'h0000_0030;
        if2.wdata_i    = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("rst_busy stall c0", {31'h0, if2.stall_o}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy stall c1", {31'h0, if2.stall_o}, 32'h1);
        rst = 1'b1;
        clear2();
        #1;
        chk("rst_busy stall", {31'h0, if2.stall_o}, 32'h0);
        chk("rst_busy done",  {31'h0, if2.done_o},  32'h0);
        chk("rst_busy err",   {31'h0, if2.err_o},   32'h0);
        chk("rst_busy rdata", if2.rdata_o,          32'h0);
        @(posedge clk); #1 rst = 1'b0;
        apply_and_check("after_rst load", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 32'h1111_1111);

        // Seed the model with the table's surviving contents.
        model_mem[word_of(32'h10)] = 32'hDEAD_BEEF;
        model_mem[word_of(32'h20)] = 32'hCAFE_F00D;
        model_mem[word_of(32'h400)] = 32'h1234_5678;
        model_mem[word_of(32'h30)] = 32'h1111_1111;
        model_last = 32'h1111_1111;

        for (int n = 0; n < 40; n++) begin
            logic        rd, wr, legal;
            logic [31:0] a, d, exp;
            int          kind, w;
            a    = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            d    = $urandom;
            kind = $urandom_range(0, 9);
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind == 0) begin
                a  = a | 32'($urandom_range(1, 3));
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
            end else if (kind == 1) begin
                rd = 1'b1;
                wr = 1'b1;
            end else if (kind <= 5) begin
                wr = 1'b1;
            end else begin
                rd = 1'b1;
            end
            w = word_of(a);
            if (rd && !wr && !model_mem.exists(w) && (a % 4 == 0)) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            legal = spec_legal(rd, wr, a);
            if (legal && wr) model_mem[w] = d;
            if (legal && rd) model_last = model_mem[w];
            exp = model_last;
            apply_and_check($sformatf("rnd%0d", n), rd, wr, a, d, legal, exp);
        end

        // LATENCY=1 instance: a store, then loads held back-to-back.
        @(posedge clk); #1;
        if1.memwrite_i = 1'b1;
        if1.addr_i     = 32'h0000_0044;
        if1.wdata_i    = 32'h55AA_55AA;
        for (int c = 0; c < L1 + 2; c++) begin
            @(negedge clk);
            chk($sformatf("L1 store stall c%0d", c), {31'h0, if1.stall_o}, {31'h0, c <= L1});
            chk($sformatf("L1 store done c%0d", c),  {31'h0, if1.done_o},  {31'h0, c == L1 + 1});
        end
        @(posedge clk); #1;
        clear1();
        @(posedge clk); #1;
        if1.memread_i = 1'b1;
        if1.addr_i    = 32'h0000_0044;
        for (int c = 0; c < 3 * (L1 + 2); c++) begin
            @(negedge clk);
            chk($sformatf("L1 b2b stall c%0d", c), {31'h0, if1.stall_o},
                {31'h0, (c % (L1 + 2)) <= L1});
            chk($sformatf("L1 b2b done c%0d", c), {31'h0, if1.done_o},
                {31'h0, (c % (L1 + 2)) == L1 + 1});
            if ((c % (L1 + 2)) == L1 + 1) begin
                chk($sformatf("L1 b2b rdata c%0d", c), if1.rdata_o, 32'h55AA_55AA);
            end
        end
        @(posedge clk); #1;
        clear1();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
